// File: rtl/signed_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : signed_window_accumulator
// Description : Accepts a window of 2**LOG2_N signed samples over a
//               valid/ready handshake and reports the window sum, the mean
//               (arithmetic shift, floor toward -inf), and the window min/max.
//               Results are held on a valid/ack output handshake.
// Ports       : clk       - rising-edge clock
//               rst       - synchronous active-high reset
//               start     - begin a new window (honoured only when idle)
//               in_valid  - upstream sample valid
//               in_data   - signed sample, DATA_W bits
//               in_ready  - sample accepted this cycle when in_valid is high
//               out_valid - sum/mean/min_val/max_val valid, held until out_ack
//               out_ack   - consumer has taken the result
//               sum       - signed window sum, ACC_W bits
//               mean      - sum >>> LOG2_N, DATA_W bits
//               min_val   - most negative sample of the window
//               max_val   - most positive sample of the window
//               busy      - high while accumulating or holding a result
// Revision    : 1.0 - initial release
// ============================================================================
module signed_window_accumulator #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 3,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [ACC_W-1:0]  sum,
    output logic [DATA_W-1:0] mean,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val,
    output logic              busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_acc  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam int                c_n    = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] c_last = LOG2_N'(c_n - 1);

    // Seeds for the running extremes: the first accepted sample always
    // replaces both of them.
    localparam logic signed [DATA_W-1:0] c_pos_max = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_neg_max = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0]               r_state;
    logic [LOG2_N-1:0]        r_count;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_min;
    logic signed [DATA_W-1:0] r_max;

    logic [ACC_W-1:0]         r_sum;
    logic [DATA_W-1:0]        r_mean;
    logic [DATA_W-1:0]        r_min_val;
    logic [DATA_W-1:0]        r_max_val;

    logic                     w_accept;
    logic signed [DATA_W-1:0] w_sample;
    logic signed [ACC_W-1:0]  w_sample_ext;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [DATA_W-1:0] w_min_next;
    logic signed [DATA_W-1:0] w_max_next;

    always_comb begin
        w_accept     = in_valid && (r_state == c_st_acc);
        w_sample     = $signed(in_data);
        w_sample_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
        w_acc_next   = r_acc + w_sample_ext;
        w_min_next   = (w_sample < r_min) ? w_sample : r_min;
        w_max_next   = (w_sample > r_max) ? w_sample : r_max;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_count   <= '0;
            r_acc     <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_sum     <= '0;
            r_mean    <= '0;
            r_min_val <= '0;
            r_max_val <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_acc;
                        r_count <= '0;
                        r_acc   <= '0;
                        r_min   <= c_pos_max;
                        r_max   <= c_neg_max;
                    end
                end
                c_st_acc: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_next;
                        r_min   <= w_min_next;
                        r_max   <= w_max_next;
                        r_count <= r_count + 1'b1;
                        // Result registers are loaded straight from the
                        // next-state values so out_valid and the data appear
                        // on the same edge that takes the last sample.
                        if (r_count == c_last) begin
                            r_state   <= c_st_done;
                            r_sum     <= w_acc_next;
                            r_mean    <= w_acc_next[LOG2_N+DATA_W-1:LOG2_N];
                            r_min_val <= w_min_next;
                            r_max_val <= w_max_next;
                        end
                    end
                end
                c_st_done: begin
                    // A simultaneous start is deliberately dropped here.
                    if (out_ack) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register, so they
    // change only on clock edges.
    assign in_ready  = (r_state == c_st_acc);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state == c_st_acc) || (r_state == c_st_done);

    assign sum     = r_sum;
    assign mean    = r_mean;
    assign min_val = r_min_val;
    assign max_val = r_max_val;

endmodule
`default_nettype wire

// File: tb/tb_signed_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_window_accumulator
// Description : Self-checking bench for signed_window_accumulator. Windows of
//               directed and random samples are fed with optional stalls and
//               results are compared against a plain-arithmetic model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_window_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ack;
    logic [23:0] sum;
    logic [15:0] mean;
    logic [15:0] min_val;
    logic [15:0] max_val;
    logic        busy;

    int checks;
    int errors;
    int win[8];

    signed_window_accumulator #(
        .DATA_W(16),
        .LOG2_N(3),
        .ACC_W (24)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .sum      (sum),
        .mean     (mean),
        .min_val  (min_val),
        .max_val  (max_val),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Floor division by the window length, done with ordinary integers.
    function automatic int floor_div8(input int s);
        if (s >= 0) return s / 8;
        return -((-s + 7) / 8);
    endfunction

    task automatic check_model();
        int s;
        int mn;
        int mx;
        s  = 0;
        mn = win[0];
        mx = win[0];
        foreach (win[i]) begin
            s += win[i];
            if (win[i] < mn) mn = win[i];
            if (win[i] > mx) mx = win[i];
        end
        check("sum",  32'(sum),     32'(s) & 32'h00FF_FFFF);
        check("mean", 32'(mean),    32'(floor_div8(s)) & 32'h0000_FFFF);
        check("min",  32'(min_val), 32'(mn) & 32'h0000_FFFF);
        check("max",  32'(max_val), 32'(mx) & 32'h0000_FFFF);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum"},   32'(sum),       0);
        check({tag, "_mean"},  32'(mean),      0);
        check({tag, "_min"},   32'(min_val),   0);
        check({tag, "_max"},   32'(max_val),   0);
        check({tag, "_ready"}, 32'(in_ready),  0);
        check({tag, "_ovld"},  32'(out_valid), 0);
        check({tag, "_busy"},  32'(busy),      0);
    endtask

    // Feeds win[] as one window; gaps inserts random stall cycles carrying
    // junk data that must not be counted.
    task automatic run_window(input bit gaps);
        int n;
        int cyc;
        bit v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("acc_ready", 32'(in_ready), 1);
        check("acc_busy",  32'(busy),     1);
        n   = 0;
        cyc = 0;
        while (n < 8 && cyc < 200) begin
            v        = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data  = v ? 16'(win[n]) : 16'($urandom);
            @(negedge clk);
            cyc++;
            if (v) n++;
            in_valid = 1'b0;
            if (n < 8) check("ovld_early", 32'(out_valid), 0);
        end
        check("ovld_done",  32'(out_valid), 1);
        check("ready_done", 32'(in_ready),  0);
        check("busy_done",  32'(busy),      1);
        check_model();
    endtask

    task automatic ack_result();
        logic [23:0] held;
        held    = sum;
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("ack_ovld", 32'(out_valid), 0);
        check("ack_busy", 32'(busy),      0);
        check("ack_hold", 32'(sum),       32'(held));
    endtask

    initial begin
        logic [15:0] r;
        logic [23:0] s_hold;
        logic [15:0] m_hold;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("t1");

        // Valid while idle must not be accepted or start anything.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_ready", 32'(in_ready), 0);
        check("idle_busy",  32'(busy),     0);

        // T2: constant positive samples back to back.
        foreach (win[i]) win[i] = 7;
        run_window(1'b0);
        ack_result();

        // T3: +7/-7 alternating with stalls.
        foreach (win[i]) win[i] = (i % 2 == 0) ? 7 : -7;
        run_window(1'b1);
        ack_result();

        // T4: all most-negative.
        foreach (win[i]) win[i] = -32768;
        run_window(1'b0);
        ack_result();

        // T5: floor of a small negative sum.
        foreach (win[i]) win[i] = (i == 7) ? -1 : 0;
        run_window(1'b1);
        ack_result();

        // Random windows.
        for (int k = 0; k < 6; k++) begin
            foreach (win[i]) begin
                r      = 16'($urandom);
                win[i] = int'($signed(r));
            end
            run_window(k[0]);
            ack_result();
        end

        // T6a: reset after three samples discards the window and clears outputs.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("t6rst");

        // T6b: result held without ack; start and valid in DONE are ignored.
        foreach (win[i]) win[i] = 100 * (i + 1) - 450;
        run_window(1'b0);
        s_hold = sum;
        m_hold = min_val;
        for (int c = 0; c < 5; c++) begin
            start    = 1'b1;
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(negedge clk);
            check("hold_ovld", 32'(out_valid), 1);
            check("hold_sum",  32'(sum),       32'(s_hold));
            check("hold_min",  32'(min_val),   32'(m_hold));
        end
        in_valid = 1'b0;

        // T6c: start together with ack -> idle, no new window.
        start   = 1'b1;
        out_ack = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        out_ack = 1'b0;
        check("sa_ovld", 32'(out_valid), 0);
        check("sa_busy", 32'(busy),      0);
        @(negedge clk);
        check("sa_busy2",  32'(busy),     0);
        check("sa_ready2", 32'(in_ready), 0);
        check("sa_sum",    32'(sum),      32'(s_hold));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
